// File: rtl/core_pkg.sv
// Core package shared across the codebase.
//
// Holds the common word/strobe typedefs, the APB arbiter FSM state type and
// a small index-wrapping helper used by the round-robin pointer.
//
// Contents:
//   word_t      - 32-bit data/address word
//   strb_t      - 4-bit byte strobe
//   arb_state_e - APB arbiter FSM states (IDLE, SETUP, ACCESS)
//   wrap_next   - increment an index, wrapping at a given count
package core_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_e;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_arb_pick.sv
// Combinational winner selection for the APB arbiter.
//
// Scans the request vector starting at index ptr, wrapping around, and
// reports the first requesting port. Tying ptr to zero gives plain
// lowest-index-wins priority.
//
// Ports:
//   req    (in)  one request bit per port
//   ptr    (in)  index where the search begins
//   onehot (out) one-hot winner, all zero when nobody requests
//   idx    (out) index of the winner, zero when nobody requests
module apb_arb_pick #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]         onehot,
  output logic [$clog2(NUM_PORTS)-1:0] idx
);

  localparam int IW = $clog2(NUM_PORTS);

  logic found;
  int   cand;

  // Search position k maps to port (ptr + k) mod NUM_PORTS; the inner loop
  // keeps every select index a loop constant.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!found && (j == cand) && req[j]) begin
          found     = 1'b1;
          idx       = IW'(j);
          onehot[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// N-to-1 APB arbiter.
//
// Several upstream APB requesters share one downstream APB completer. A
// winner is chosen only while idle, then the downstream transfer runs
// through SETUP and ACCESS with the granted port's request muxed through.
// The response is steered back to the granted port only.
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, round-robin arbitration; otherwise
//                        fixed priority with the lowest index winning.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_psel/s_penable/s_pwrite    upstream controls, one bit per port
//   s_paddr/s_pwdata/s_pwstrb    upstream address, write data, strobes
//   s_pready/s_pslverr/s_prdata  upstream response, one lane per port
//   m_psel/m_penable/m_pwrite    downstream controls
//   m_paddr/m_pwdata/m_pwstrb    downstream address, write data, strobes
//   m_pready/m_pslverr/m_prdata  downstream response
//   grant_id                     currently or last granted port
module apb_arbiter
  import core_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             s_psel,
  input  logic [NUM_PORTS-1:0]             s_penable,
  input  logic [NUM_PORTS-1:0]             s_pwrite,
  input  logic [NUM_PORTS-1:0][31:0]       s_paddr,
  input  logic [NUM_PORTS-1:0][31:0]       s_pwdata,
  input  logic [NUM_PORTS-1:0][3:0]        s_pwstrb,
  output logic [NUM_PORTS-1:0]             s_pready,
  output logic [NUM_PORTS-1:0]             s_pslverr,
  output logic [NUM_PORTS-1:0][31:0]       s_prdata,
  output logic                             m_psel,
  output logic                             m_penable,
  output logic                             m_pwrite,
  output logic [31:0]                      m_paddr,
  output logic [31:0]                      m_pwdata,
  output logic [3:0]                       m_pwstrb,
  input  logic                             m_pready,
  input  logic                             m_pslverr,
  input  logic [31:0]                      m_prdata,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_id
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_e             state;
  logic [NUM_PORTS-1:0]   pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          search_ptr;
  logic                   resp_take;
  logic                   unused_penable;

  // The upstream enable phase carries no information the arbiter needs:
  // psel alone marks a pending request.
  assign unused_penable = ^s_penable;

  apb_arb_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .req    (s_psel),
    .ptr    (search_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  // rr_ptr holds the port just after the last grant, so a fresh reset
  // starts the search at port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && |pick_onehot) begin
      rr_ptr <= IW'(wrap_next(int'(pick_idx), NUM_PORTS));
    end
  end

  assign search_ptr = rr_ptr;
`else
  assign search_ptr = '0;
`endif

  // Grant is captured only when leaving IDLE, so later requests can never
  // disturb a transfer already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|pick_onehot) begin
            grant_id <= pick_idx;
            state    <= SETUP;
          end
        end
        SETUP:   state <= ACCESS;
        ACCESS:  if (m_pready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m_psel    = (state != IDLE);
  assign m_penable = (state == ACCESS);
  assign m_pwrite  = s_pwrite[grant_id];
  assign m_paddr   = s_paddr[grant_id];
  assign m_pwdata  = s_pwdata[grant_id];
  assign m_pwstrb  = s_pwstrb[grant_id];

  // A granted port that already dropped psel still sees the downstream
  // transfer finish, but its response is swallowed rather than delivered.
  assign resp_take = (state == ACCESS) && m_pready && s_psel[grant_id];

  // Response lanes stay zero except on the granted port's completion cycle.
  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (resp_take && (grant_id == IW'(i))) begin
        s_pready[i]  = 1'b1;
        s_pslverr[i] = m_pslverr;
        s_prdata[i]  = m_prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter (two ports).
//
// A transaction-level reference tracks which port owns the downstream bus
// and how far its transfer has progressed; every falling edge the DUT
// outputs are compared with what that reference says they must be. Directed
// scenarios add literal checks on counts, grant order and data values.
module tb_apb_arbiter;

  localparam int N = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N-1:0]       s_psel = '0;
  logic [N-1:0]       s_penable = '0;
  logic [N-1:0]       s_pwrite = '0;
  logic [N-1:0][31:0] s_paddr = '0;
  logic [N-1:0][31:0] s_pwdata = '0;
  logic [N-1:0][3:0]  s_pwstrb = '0;
  logic [N-1:0]       s_pready;
  logic [N-1:0]       s_pslverr;
  logic [N-1:0][31:0] s_prdata;
  logic               m_psel, m_penable, m_pwrite;
  logic [31:0]        m_paddr, m_pwdata;
  logic [3:0]         m_pwstrb;
  logic               m_pready = 1'b0;
  logic               m_pslverr = 1'b0;
  logic [31:0]        m_prdata = '0;
  logic [$clog2(N)-1:0] grant_id;

  always #5 clk = ~clk;

  apb_arbiter #(.NUM_PORTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pwrite  (s_pwrite),
    .s_paddr   (s_paddr),
    .s_pwdata  (s_pwdata),
    .s_pwstrb  (s_pwstrb),
    .s_pready  (s_pready),
    .s_pslverr (s_pslverr),
    .s_prdata  (s_prdata),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_pwstrb  (m_pwstrb),
    .m_pready  (m_pready),
    .m_pslverr (m_pslverr),
    .m_prdata  (m_prdata),
    .grant_id  (grant_id)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Reference: bus owner and transfer progress (0 free, 1 setup, 2 access).
  int mdl_phase = 0;
  int mdl_owner = 0;
  int mdl_next  = 0;

  function automatic int mdlPick(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin : reference
    int w;
    if (rst) begin
      mdl_phase <= 0;
      mdl_owner <= 0;
      mdl_next  <= 0;
    end else if (mdl_phase == 0) begin
      if (|s_psel) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = mdlPick(s_psel, mdl_next);
        mdl_next <= (w + 1) % N;
`else
        w = mdlPick(s_psel, 0);
`endif
        mdl_owner <= w;
        mdl_phase <= 1;
      end
    end else if (mdl_phase == 1) begin
      mdl_phase <= 2;
    end else if (m_pready) begin
      mdl_phase <= 0;
    end
  end

  // Observation counters and logs (written only here).
  int   cnt_psel = 0, cnt_penable = 0;
  int   cnt_rdy[N] = '{default: 0};
  int   cnt_err0 = 0;
  int   grant_log[$];
  logic [31:0] setup_addr = '0, setup_wdata = '0;
  logic [31:0] cap_rdata1 = '0, cap_rdata0_at1 = '0;
  logic pend_both = 1'b0;

  always @(negedge clk) begin : compare
    logic          done;
    logic [N-1:0]  exp_rdy;
    done    = (mdl_phase == 2) && m_pready && s_psel[mdl_owner];
    exp_rdy = '0;
    if (done) exp_rdy[mdl_owner] = 1'b1;
    checkOutput("m_psel", {31'b0, m_psel}, {31'b0, mdl_phase != 0});
    checkOutput("m_penable", {31'b0, m_penable}, {31'b0, mdl_phase == 2});
    checkOutput("grant_id", 32'(grant_id), 32'(mdl_owner));
    checkOutput("m_paddr", m_paddr, s_paddr[mdl_owner]);
    checkOutput("m_pwdata", m_pwdata, s_pwdata[mdl_owner]);
    checkOutput("m_pwstrb", {28'b0, m_pwstrb}, {28'b0, s_pwstrb[mdl_owner]});
    if (mdl_phase != 0)
      checkOutput("m_pwrite", {31'b0, m_pwrite}, {31'b0, s_pwrite[mdl_owner]});
    checkOutput("s_pready", 32'(s_pready), 32'(exp_rdy));
    checkOutput("s_pslverr", 32'(s_pslverr), exp_rdy[mdl_owner] ? 32'(exp_rdy & {N{m_pslverr}}) : 32'd0);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("s_prdata[%0d]", i), s_prdata[i], exp_rdy[i] ? m_prdata : 32'd0);

    if (m_psel) cnt_psel++;
    if (m_penable) cnt_penable++;
    for (int i = 0; i < N; i++) if (s_pready[i]) cnt_rdy[i]++;
    if (s_pslverr[0]) cnt_err0++;
    if (m_psel && !m_penable) begin
      grant_log.push_back(int'(grant_id));
      setup_addr  = m_paddr;
      setup_wdata = m_pwdata;
    end
    if (s_pready[1]) begin
      cap_rdata1     = s_prdata[1];
      cap_rdata0_at1 = s_prdata[0];
    end
`ifndef ARB_ROUND_ROBIN_EN
    if (!m_psel && s_psel[0] && s_psel[1]) begin
      pend_both = 1'b1;
    end else if (m_psel && !m_penable && pend_both) begin
      checkOutput("fixed_prio_winner", 32'(grant_id), 32'd0);
      pend_both = 1'b0;
    end
`endif
  end

  // Downstream completer: ready after slv_waits ACCESS cycles.
  int slv_waits = 0;
  int slv_cnt   = 0;
  always begin
    @(posedge clk);
    #2;
    if (m_psel && m_penable) begin
      m_pready = (slv_cnt >= slv_waits);
      slv_cnt++;
    end else begin
      m_pready = 1'b0;
      slv_cnt  = 0;
    end
  end

  task automatic applyStimulus(input int p, input logic sel, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    s_psel[p]    = sel;
    s_penable[p] = 1'b0;
    s_pwrite[p]  = wr;
    s_paddr[p]   = addr;
    s_pwdata[p]  = data;
    s_pwstrb[p]  = 4'hF ^ 4'(p);
  endtask

  // One upstream APB transfer; called at a point just after a rising edge.
  task automatic doTransfer(input int p, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data);
    int  guard;
    logic got;
    guard = 0;
    got   = 1'b0;
    applyStimulus(p, 1'b1, wr, addr, data);
    @(posedge clk);
    #1 s_penable[p] = 1'b1;
    while (!got && guard < 60) begin
      @(negedge clk);
      if (s_pready[p]) got = 1'b1;
      guard++;
    end
    if (!got) checkOutput($sformatf("pready_timeout_port%0d", p), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_psel[p]    = 1'b0;
    s_penable[p] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b_psel, b_pen, b_r0, b_r1, b_e0, b_log;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("reset_m_psel", {31'b0, m_psel}, 32'd0);
    checkOutput("reset_s_pready", 32'(s_pready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single write on port 0 with zero wait states.
    $display("[TB] single write on port 0");
    b_psel = cnt_psel; b_pen = cnt_penable; b_r0 = cnt_rdy[0]; b_r1 = cnt_rdy[1];
    doTransfer(0, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    checkOutput("single_psel_cycles", 32'(cnt_psel - b_psel), 32'd2);
    checkOutput("single_penable_cycles", 32'(cnt_penable - b_pen), 32'd1);
    checkOutput("single_pready0_pulses", 32'(cnt_rdy[0] - b_r0), 32'd1);
    checkOutput("single_pready1_pulses", 32'(cnt_rdy[1] - b_r1), 32'd0);
    checkOutput("single_setup_addr", setup_addr, 32'h1000_0004);
    checkOutput("single_setup_wdata", setup_wdata, 32'hDEAD_BEEF);

    // Read on port 1 returning a known word.
    $display("[TB] read on port 1");
    @(posedge clk); #1;
    m_prdata = 32'h1234_5678;
    doTransfer(1, 1'b0, 32'h2000_0010, 32'h0);
    checkOutput("read_prdata1", cap_rdata1, 32'h1234_5678);
    checkOutput("read_prdata0", cap_rdata0_at1, 32'h0);
    m_prdata = 32'hA5A5_0000;

    // Simultaneous requests; port 0 comes straight back for a second go.
    $display("[TB] simultaneous requests");
    b_log = grant_log.size();
    fork
      begin
        doTransfer(0, 1'b1, 32'h0000_0100, 32'h1111_1111);
        doTransfer(0, 1'b1, 32'h0000_0104, 32'h2222_2222);
      end
      doTransfer(1, 1'b1, 32'h0000_0200, 32'h3333_3333);
    join
    if (grant_log.size() >= b_log + 3) begin
`ifdef ARB_ROUND_ROBIN_EN
      checkOutput("pair_order_0", 32'(grant_log[b_log]), 32'd0);
      checkOutput("pair_order_1", 32'(grant_log[b_log+1]), 32'd1);
      checkOutput("pair_order_2", 32'(grant_log[b_log+2]), 32'd0);
`else
      checkOutput("pair_order_0", 32'(grant_log[b_log]), 32'd0);
      checkOutput("pair_order_1", 32'(grant_log[b_log+1]), 32'd0);
      checkOutput("pair_order_2", 32'(grant_log[b_log+2]), 32'd1);
`endif
    end else begin
      checkOutput("pair_grant_count", 32'(grant_log.size() - b_log), 32'd3);
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Port 1 requests continuously, port 0 every few cycles.
    $display("[TB] fixed priority under contention");
    b_log = grant_log.size();
    fork
      for (int t = 0; t < 6; t++) doTransfer(1, 1'b0, 32'h0000_0300 + 32'(t), 32'h0);
      for (int t = 0; t < 3; t++) begin
        repeat (4) @(posedge clk);
        #1 doTransfer(0, 1'b1, 32'h0000_0400 + 32'(t), 32'h4444_0000 + 32'(t));
      end
    join
    checkOutput("contention_grants", 32'(grant_log.size() - b_log), 32'd9);
`endif

    // Wait states with an error response; port 1 arrives mid-transfer.
    $display("[TB] wait states and error");
    @(posedge clk); #1;
    slv_waits = 5;
    m_pslverr = 1'b1;
    b_pen = cnt_penable; b_r0 = cnt_rdy[0]; b_e0 = cnt_err0; b_log = grant_log.size();
    fork
      doTransfer(0, 1'b1, 32'h0000_0500, 32'h5555_5555);
      begin
        repeat (2) @(posedge clk);
        #1 doTransfer(1, 1'b1, 32'h0000_0600, 32'h6666_6666);
      end
    join
    checkOutput("wait_pready0_pulses", 32'(cnt_rdy[0] - b_r0), 32'd1);
    checkOutput("wait_pslverr0_cycles", 32'(cnt_err0 - b_e0), 32'd1);
    checkOutput("wait_penable_cycles", 32'(cnt_penable - b_pen), 32'd12);
    if (grant_log.size() >= b_log + 2) begin
      checkOutput("wait_order_0", 32'(grant_log[b_log]), 32'd0);
      checkOutput("wait_order_1", 32'(grant_log[b_log+1]), 32'd1);
    end else begin
      checkOutput("wait_grant_count", 32'(grant_log.size() - b_log), 32'd2);
    end
    m_pslverr = 1'b0;

    // Reset asserted while port 1 is in ACCESS.
    $display("[TB] reset during access");
    slv_waits = 3;
    b_r1 = cnt_rdy[1];
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
    begin
      int guard;
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!m_penable && guard < 20);
      checkOutput("midreset_reached_access", {31'b0, m_penable}, 32'd1);
    end
    #1 rst = 1'b1;
    #1;
    checkOutput("midreset_m_psel", {31'b0, m_psel}, 32'd0);
    checkOutput("midreset_m_penable", {31'b0, m_penable}, 32'd0);
    checkOutput("midreset_grant_id", 32'(grant_id), 32'd0);
    checkOutput("midreset_s_pready", 32'(s_pready), 32'd0);
    s_psel[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    checkOutput("midreset_no_pready1", 32'(cnt_rdy[1] - b_r1), 32'd0);

    // First transfer after reset release.
    $display("[TB] transfer after reset");
    slv_waits = 1;
    @(posedge clk); #1;
    doTransfer(1, 1'b1, 32'h0000_0800, 32'h8888_8888);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
